// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared constants, state types and sample helper for the trace streamer
// Purpose: one place for trace geometry, frame markers and FSM encodings so the
//   streamer, its RAM and the bench agree on sizes.
// Ports: none (package).
package trace_pkg;

  localparam int         SAMPLES    = 1024;
  localparam int         ADDR_W     = 10;
  localparam int         META_BYTES = 48;
  localparam logic [7:0] DONE_MARK  = 8'hFF;
  localparam logic [7:0] SYNC0      = 8'hA5;
  localparam logic [7:0] SYNC1      = 8'h5A;
  // sync pair + metadata + samples + checksum
  localparam int         FRAME_LEN  = 2 + META_BYTES + SAMPLES + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_FULL,
    ST_SEND_SYNC,
    ST_SEND_META,
    ST_SEND_SAMP,
    ST_SEND_SUM
  } state_t;

  // ISSUE is the single cycle tx_dv_o is high; WAIT holds the byte until tx_done_i.
  typedef enum logic {
    PH_ISSUE,
    PH_WAIT
  } phase_t;

  // Real samples never reach DONE_MARK, so the marker stays unambiguous in the trace.
  function automatic logic [7:0] sat_sample(input logic [7:0] s);
    return (s == DONE_MARK) ? (DONE_MARK - 8'd1) : s;
  endfunction

endpackage

// File: rtl/trace_ram.sv
// rtl/trace_ram.sv - simple dual-port trace buffer with registered read
// Purpose: DEPTH x 8 sample store; one write port, one read port, read data one
//   cycle after the address. Contents are not reset.
// Ports:
//   clk    in  1   clock
//   we     in  1   write enable
//   waddr  in  AW  write address
//   wdata  in  8   write data
//   raddr  in  AW  read address
//   rdata  out 8   mem[raddr] from the previous cycle
module trace_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/trace_uart_streamer.sv
// rtl/trace_uart_streamer.sv - captures a TDC sample trace and uploads it as one framed record
// Purpose: on trig_i store SAMPLES decoded values (done_i cycle marked), then on
//   send_i emit A5 5A, metadata, samples and an XOR checksum one byte at a time
//   through a uart_tx-style dv/done handshake.
// Ports:
//   clk        in  1    clock
//   rst        in  1    synchronous active-high reset
//   trig_i     in  1    cipher start strobe; starts capture from IDLE
//   done_i     in  1    cipher done; stores DONE_MARK for that capture cycle
//   sample_i   in  8    decoded TDC value, valid every cycle
//   meta_i     in  384  {PT,key,CT}, first byte in [383:376]; latched on send_i
//   send_i     in  1    start upload of a captured trace (honoured in FULL only)
//   tx_done_i  in  1    transmitter finished the current byte
//   tx_dv_o    out 1    one-cycle strobe per byte
//   tx_byte_o  out 8    byte for the transmitter, held until tx_done_i
//   busy_o     out 1    capturing or sending
//   ready_o    out 1    trace captured, not yet sent
//   overrun_o  out 1    sticky: trig_i seen while not IDLE
module trace_uart_streamer
  import trace_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    trig_i,
  input  logic                    done_i,
  input  logic [7:0]              sample_i,
  input  logic [8*META_BYTES-1:0] meta_i,
  input  logic                    send_i,
  input  logic                    tx_done_i,
  output logic                    tx_dv_o,
  output logic [7:0]              tx_byte_o,
  output logic                    busy_o,
  output logic                    ready_o,
  output logic                    overrun_o
);

  localparam int                MW        = 8 * META_BYTES;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SAMPLES - 1);
  localparam logic [5:0]        LAST_META = 6'(META_BYTES - 1);

  state_t            state;
  phase_t            phase;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W-1:0] raddr;
  logic [ADDR_W-1:0] ram_raddr;
  logic [5:0]        byte_cnt;
  logic [7:0]        csum;
  logic [MW-1:0]     meta_sr;
  logic              ram_we;
  logic [7:0]        ram_wdata;
  logic [7:0]        rdata;

  assign ram_we    = (state == ST_CAPTURE);
  assign ram_wdata = done_i ? DONE_MARK : sat_sample(sample_i);

  // raddr is the sample currently on tx_byte_o, so the RAM looks one ahead and the
  // next sample is ready after the one-cycle ISSUE phase. Outside SEND_SAMP the
  // address parks at 0 so sample 0 is waiting when the metadata runs out.
  assign ram_raddr = (state == ST_SEND_SAMP) ? (raddr + 1'b1) : '0;

  assign busy_o  = (state != ST_IDLE) && (state != ST_FULL);
  assign ready_o = (state == ST_FULL);

  trace_ram #(
    .DEPTH (SAMPLES),
    .AW    (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      phase     <= PH_ISSUE;
      waddr     <= '0;
      raddr     <= '0;
      byte_cnt  <= '0;
      csum      <= '0;
      meta_sr   <= '0;
      tx_dv_o   <= 1'b0;
      tx_byte_o <= '0;
      overrun_o <= 1'b0;
    end else begin
      tx_dv_o <= 1'b0;
      if (trig_i && (state != ST_IDLE)) begin
        overrun_o <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (trig_i) begin
            waddr <= '0;
            state <= ST_CAPTURE;
          end
        end

        ST_CAPTURE: begin
          waddr <= waddr + 1'b1;
          if (waddr == LAST_ADDR) begin
            state <= ST_FULL;
          end
        end

        ST_FULL: begin
          if (send_i) begin
            meta_sr   <= meta_i;
            csum      <= '0;
            byte_cnt  <= '0;
            tx_byte_o <= SYNC0;
            tx_dv_o   <= 1'b1;
            phase     <= PH_ISSUE;
            state     <= ST_SEND_SYNC;
          end
        end

        default: begin
          if (phase == PH_ISSUE) begin
            phase <= PH_WAIT;
          end else if (tx_done_i) begin
            // Byte accepted: load the next one and strobe it out.
            phase   <= PH_ISSUE;
            tx_dv_o <= 1'b1;
            case (state)
              ST_SEND_SYNC: begin
                if (byte_cnt == 6'd0) begin
                  tx_byte_o <= SYNC1;
                  byte_cnt  <= 6'd1;
                end else begin
                  tx_byte_o <= meta_sr[MW-1 -: 8];
                  csum      <= csum ^ meta_sr[MW-1 -: 8];
                  meta_sr   <= meta_sr << 8;
                  byte_cnt  <= '0;
                  state     <= ST_SEND_META;
                end
              end
              ST_SEND_META: begin
                if (byte_cnt == LAST_META) begin
                  tx_byte_o <= rdata;
                  csum      <= csum ^ rdata;
                  raddr     <= '0;
                  state     <= ST_SEND_SAMP;
                end else begin
                  tx_byte_o <= meta_sr[MW-1 -: 8];
                  csum      <= csum ^ meta_sr[MW-1 -: 8];
                  meta_sr   <= meta_sr << 8;
                  byte_cnt  <= byte_cnt + 1'b1;
                end
              end
              ST_SEND_SAMP: begin
                if (raddr == LAST_ADDR) begin
                  tx_byte_o <= csum;
                  state     <= ST_SEND_SUM;
                end else begin
                  tx_byte_o <= rdata;
                  csum      <= csum ^ rdata;
                  raddr     <= raddr + 1'b1;
                end
              end
              ST_SEND_SUM: begin
                // Checksum byte done: frame complete, no further strobe.
                tx_dv_o <= 1'b0;
                state   <= ST_IDLE;
              end
              default: begin
                tx_dv_o <= 1'b0;
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trace_uart_streamer.sv
// tb/tb_trace_uart_streamer.sv - directed self-checking bench for trace_uart_streamer
module tb_trace_uart_streamer;
  import trace_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         trig_i;
  logic         done_i;
  logic [7:0]   sample_i;
  logic [383:0] meta_i;
  logic         send_i;
  logic         tx_done_i = 1'b0;
  logic         tx_dv_o;
  logic [7:0]   tx_byte_o;
  logic         busy_o;
  logic         ready_o;
  logic         overrun_o;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0] rec [0:2047];
  int         nrec     = 0;
  int         pend     = 0;
  int         tx_lat   = 10;
  logic [7:0] cur_byte = 8'h00;
  int         unstable = 0;
  int         extra_dv = 0;
  logic       stub_clr = 1'b0;

  logic [7:0] samp [0:SAMPLES-1];
  logic [7:0] expf [0:FRAME_LEN-1];

  trace_uart_streamer dut (
    .clk       (clk),
    .rst       (rst),
    .trig_i    (trig_i),
    .done_i    (done_i),
    .sample_i  (sample_i),
    .meta_i    (meta_i),
    .send_i    (send_i),
    .tx_done_i (tx_done_i),
    .tx_dv_o   (tx_dv_o),
    .tx_byte_o (tx_byte_o),
    .busy_o    (busy_o),
    .ready_o   (ready_o),
    .overrun_o (overrun_o)
  );

  always #5 clk = ~clk;

  // uart_tx stand-in: records each strobed byte, answers tx_done_i tx_lat cycles later,
  // and notes any byte change or extra strobe while a byte is in flight.
  always begin
    @(posedge clk);
    #1;
    tx_done_i = 1'b0;
    if (stub_clr) begin
      pend = 0;
    end else if (pend > 0) begin
      if (tx_byte_o !== cur_byte) unstable++;
      if (tx_dv_o) extra_dv++;
      pend--;
      if (pend == 0) tx_done_i = 1'b1;
    end else if (tx_dv_o) begin
      cur_byte = tx_byte_o;
      if (nrec < 2048) rec[nrec] = tx_byte_o;
      nrec++;
      pend = tx_lat;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gen(input int mode, input int k);
    case (mode)
      0:       return 8'(k);
      1:       return 8'(k * 7 + 3);
      default: return 8'(255 - (k % 256));
    endcase
  endfunction

  task automatic capture(input int mode, input int done_at, input int trig_at, input int send_at);
    logic [7:0] g;
    trig_i = 1'b1;
    tick;
    trig_i = 1'b0;
    for (int k = 0; k < SAMPLES; k++) begin
      g        = gen(mode, k);
      sample_i = g;
      done_i   = (k == done_at);
      trig_i   = (k == trig_at);
      send_i   = (k == send_at);
      samp[k]  = (k == done_at) ? 8'hFF : ((g == 8'hFF) ? 8'hFE : g);
      if (k == 512) begin
        chk("busy_in_capture", busy_o, 1);
        chk("ready_in_capture", ready_o, 0);
      end
      if (k == SAMPLES - 1) chk("ready_before_last_write", ready_o, 0);
      tick;
    end
    done_i = 1'b0;
    trig_i = 1'b0;
    send_i = 1'b0;
  endtask

  task automatic build_frame;
    logic [7:0] cs;
    cs      = 8'h00;
    expf[0] = 8'hA5;
    expf[1] = 8'h5A;
    for (int k = 0; k < META_BYTES; k++) begin
      expf[2 + k] = meta_i[383 - 8 * k -: 8];
      cs = cs ^ expf[2 + k];
    end
    for (int k = 0; k < SAMPLES; k++) begin
      expf[2 + META_BYTES + k] = samp[k];
      cs = cs ^ samp[k];
    end
    expf[FRAME_LEN - 1] = cs;
  endtask

  task automatic run_frame(input string tag, input int lat, input int trig_at_byte, input logic trig_with_send);
    int cyc;
    int bad;
    int first_bad;
    tx_lat   = lat;
    nrec     = 0;
    unstable = 0;
    extra_dv = 0;
    send_i   = 1'b1;
    trig_i   = trig_with_send;
    tick;
    send_i = 1'b0;
    trig_i = 1'b0;
    chk({tag, "_dv_after_send"}, tx_dv_o, 1);
    chk({tag, "_first_byte"}, tx_byte_o, 8'hA5);
    chk({tag, "_ready_drops"}, ready_o, 0);
    cyc = 0;
    while (busy_o && cyc < 40000) begin
      trig_i = (nrec == trig_at_byte);
      tick;
      cyc++;
    end
    trig_i = 1'b0;
    chk({tag, "_frame_ends"}, busy_o, 0);
    chk({tag, "_frame_len"}, nrec, FRAME_LEN);
    bad = 0;
    first_bad = -1;
    for (int k = 0; k < FRAME_LEN; k++) begin
      if (rec[k] !== expf[k]) begin
        bad++;
        if (first_bad < 0) first_bad = k;
      end
    end
    chk({tag, "_byte_errors"}, bad, 0);
    if (bad != 0) chk({tag, "_first_bad_byte"}, rec[first_bad], expf[first_bad]);
    chk({tag, "_byte_unstable"}, unstable, 0);
    chk({tag, "_extra_dv"}, extra_dv, 0);
  endtask

  initial begin
    int cyc;
    rst      = 1'b1;
    trig_i   = 1'b0;
    done_i   = 1'b0;
    send_i   = 1'b0;
    sample_i = 8'h00;
    meta_i   = '0;
    tick;
    tick;
    chk("rst_dv", tx_dv_o, 0);
    chk("rst_byte", tx_byte_o, 8'h00);
    chk("rst_busy", busy_o, 0);
    chk("rst_ready", ready_o, 0);
    chk("rst_overrun", overrun_o, 0);
    rst = 1'b0;
    tick;

    // send_i in IDLE does nothing
    send_i = 1'b1;
    tick;
    send_i = 1'b0;
    tick;
    tick;
    chk("idle_send_dv", tx_dv_o, 0);
    chk("idle_send_bytes", nrec, 0);
    chk("idle_send_busy", busy_o, 0);

    // Frame A: ramp, send_i during capture, trig_i during SEND_SAMP, slow transmitter
    capture(0, -1, -1, 100);
    chk("A_ready", ready_o, 1);
    chk("A_busy_full", busy_o, 0);
    chk("A_capture_send_ignored", nrec, 0);
    chk("A_overrun_clear", overrun_o, 0);
    for (int k = 0; k < META_BYTES; k++) meta_i[383 - 8 * k -: 8] = 8'(k);
    build_frame();
    run_frame("A", 10, 300, 1'b0);
    chk("A_sync1", rec[1], 8'h5A);
    chk("A_meta0", rec[2], 8'h00);
    chk("A_meta15", rec[17], 8'h0F);
    chk("A_meta47", rec[49], 8'h2F);
    chk("A_samp0", rec[50], 8'h00);
    chk("A_samp254", rec[304], 8'hFE);
    chk("A_samp255_sat", rec[305], 8'hFE);
    chk("A_samp256", rec[306], 8'h00);
    chk("A_checksum", rec[1074], 8'h00);
    chk("A_overrun_send", overrun_o, 1);
    chk("A_ready_after", ready_o, 0);

    // Frame B: done mark at capture cycle 300, trig_i during capture, fastest transmitter
    for (int k = 0; k < 12; k++) meta_i[32 * k +: 32] = $urandom();
    capture(1, 300, 600, -1);
    chk("B_ready", ready_o, 1);
    chk("B_overrun_sticky", overrun_o, 1);
    build_frame();
    run_frame("B", 1, -1, 1'b0);
    chk("B_samp299", rec[349], 8'h30);
    chk("B_done_mark", rec[350], 8'hFF);
    chk("B_samp301", rec[351], 8'h3E);
    chk("B_overrun_after", overrun_o, 1);

    // Reset in the middle of SEND_META
    capture(0, -1, -1, -1);
    tx_lat = 10;
    nrec   = 0;
    send_i = 1'b1;
    tick;
    send_i = 1'b0;
    cyc = 0;
    while (nrec < 10 && cyc < 2000) begin
      tick;
      cyc++;
    end
    chk("C_reached_meta", (nrec >= 10), 1);
    rst      = 1'b1;
    stub_clr = 1'b1;
    tick;
    chk("C_rst_dv", tx_dv_o, 0);
    chk("C_rst_busy", busy_o, 0);
    chk("C_rst_ready", ready_o, 0);
    chk("C_rst_overrun", overrun_o, 0);
    rst = 1'b0;
    tick;
    tick;
    stub_clr = 1'b0;
    tick;

    // Frame D: fresh capture after reset; trig_i and send_i together in FULL
    for (int k = 0; k < 12; k++) meta_i[32 * k +: 32] = $urandom();
    capture(2, -1, -1, -1);
    chk("D_ready", ready_o, 1);
    chk("D_overrun_clear", overrun_o, 0);
    build_frame();
    run_frame("D", 1, -1, 1'b1);
    chk("D_samp0_sat", rec[50], 8'hFE);
    chk("D_samp1", rec[51], 8'hFE);
    chk("D_samp2", rec[52], 8'hFD);
    chk("D_overrun_trig_send", overrun_o, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
